// File: rtl/uart_pkg.sv
// Shared UART definitions: divider width and default, frame constants, rx FSM states.
// UART_RX_MAJORITY_EN raises the minimum divider so that three samples fit around each bit centre.
package uart_pkg;

   localparam int UART_DIV_W = 13;
   localparam logic [UART_DIV_W-1:0] UART_SPEED_DEFAULT = 13'h1869;

   localparam int   DATA_BITS  = 8;
   localparam logic STOP_LEVEL = 1'b1;

   // The bit counter needs one bit more than the divider.
   // In majority mode it has to count up to cycles_per_bit+1.
   localparam int CNT_W = UART_DIV_W + 1;

`ifdef UART_RX_MAJORITY_EN
   localparam logic [UART_DIV_W-1:0] DIV_MIN = 13'd4;
`else
   localparam logic [UART_DIV_W-1:0] DIV_MIN = 13'd3;
`endif

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic [UART_DIV_W-1:0] clamp_div(input logic [UART_DIV_W-1:0] v);
      return (v < DIV_MIN) ? DIV_MIN : v;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Synchroniser for an asynchronous, idle-high input: a chain of STAGES flops that resets to 1.
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) chain <= '1;
      else          chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a programmable divider (bit period = cycles_per_bit+1).
// Defining UART_RX_MAJORITY_EN switches each sample to a 2-of-3 vote, one clock later.
module uart_rx
   import uart_pkg::*;
#(
   parameter int                      SYNC_STAGES        = 2,
   parameter logic [UART_DIV_W-1:0]   UART_SPEED_DEFAULT = uart_pkg::UART_SPEED_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rx,
   input  logic                  set,
   input  logic [UART_DIV_W-1:0] data,
   output logic [7:0]            rx_data,
   output logic                  rx_valid,
   output logic                  frame_err,
   output logic                  busy
);

   logic rx_s;

   uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rx),
      .q       (rx_s)
   );

   rx_state_t             state, state_n;
   logic [UART_DIV_W-1:0] cycles_per_bit;
   logic [UART_DIV_W-1:0] half;
   logic [UART_DIV_W-1:0] target;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [2:0]            bit_idx, bit_idx_n;
   logic [7:0]            shift_reg, shift_n;
   logic [7:0]            rx_data_n;
   logic                  rx_valid_n, frame_err_n;
   logic                  sample_hit;
   logic                  sample_bit;

   assign half   = cycles_per_bit >> 1;
   assign target = (state == START) ? half : cycles_per_bit;

`ifdef UART_RX_MAJORITY_EN
   // Decide one clock after the centre. hist holds the rx_s values from target-1 and target.
   // A decision reloads the counter with 1, which keeps the bit period at cycles_per_bit+1.
   localparam logic [CNT_W-1:0] CNT_RESTART = CNT_W'(1);
   logic [1:0] hist;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hist <= 2'b11;
      else          hist <= {hist[0], rx_s};
   end

   assign sample_hit = (cnt == ({1'b0, target} + CNT_W'(1)));
   assign sample_bit = maj3(hist[1], hist[0], rx_s);
`else
   localparam logic [CNT_W-1:0] CNT_RESTART = '0;

   assign sample_hit = (cnt == {1'b0, target});
   assign sample_bit = rx_s;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  cycles_per_bit <= UART_SPEED_DEFAULT;
      else if (set)  cycles_per_bit <= clamp_div(data);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         shift_reg <= shift_n;
         rx_data   <= rx_data_n;
         rx_valid  <= rx_valid_n;
         frame_err <= frame_err_n;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      bit_idx_n   = bit_idx;
      shift_n     = shift_reg;
      rx_data_n   = rx_data;
      rx_valid_n  = 1'b0;
      frame_err_n = 1'b0;

      if (set) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  cnt_n   = '0;
                  state_n = START;
               end
            end

            START: begin
               if (sample_hit) begin
                  if (!sample_bit) begin
                     cnt_n     = CNT_RESTART;
                     bit_idx_n = '0;
                     state_n   = DATA;
                  end else begin
                     state_n   = IDLE;
                  end
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end

            DATA: begin
               if (sample_hit) begin
                  shift_n[bit_idx] = sample_bit;
                  cnt_n            = CNT_RESTART;
                  bit_idx_n        = bit_idx + 3'd1;
                  if (bit_idx == 3'(DATA_BITS - 1)) state_n = STOP;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end

            STOP: begin
               if (sample_hit) begin
                  rx_data_n = shift_reg;
                  if (sample_bit == STOP_LEVEL) begin
                     rx_valid_n  = 1'b1;
                     state_n     = IDLE;
                  end else begin
                     frame_err_n = 1'b1;
                     state_n     = WAIT_HIGH;
                  end
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end

            // A break keeps the receiver here, so a long low line reports exactly one error.
            WAIT_HIGH: begin
               if (rx_s) state_n = IDLE;
            end

            default: state_n = IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a vector table of single frames, plus hand-written corner sequences.
module tb_uart_rx;

   logic        clk;
   logic        reset_n;
   logic        rx;
   logic        set;
   logic [12:0] data;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   int         valid_cnt = 0;
   int         err_cnt   = 0;
   int         both_cnt  = 0;
   logic       busy_at_valid = 1'b1;
   logic [7:0] rxq[$];

`ifdef UART_RX_MAJORITY_EN
   localparam int CLAMP_P = 5;
`else
   localparam int CLAMP_P = 4;
`endif

   uart_rx dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx        (rx),
      .set       (set),
      .data      (data),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt++;
         rxq.push_back(rx_data);
         busy_at_valid = busy;
      end
      if (frame_err) err_cnt++;
      if (rx_valid && frame_err) both_cnt++;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_div(input logic [12:0] v);
      @(negedge clk);
      set  = 1'b1;
      data = v;
      @(negedge clk);
      set  = 1'b0;
   endtask

   // Drives one frame, clock by clock (each bit is p clocks), truncated to n_clks.
   // glitch >= 0 forces the line low for that single clock.
   task automatic drive_frame(input logic [7:0] b, input int p, input logic stop_lvl,
                              input int glitch, input int n_clks);
      for (int c = 0; c < n_clks; c++) begin
         int bn;
         bn = c / p;
         @(negedge clk);
         if (c == glitch)   rx = 1'b0;
         else if (bn == 0)  rx = 1'b0;
         else if (bn <= 8)  rx = b[bn-1];
         else               rx = stop_lvl;
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   typedef struct {
      logic [12:0] load;
      int          p;
      logic [7:0]  byte_v;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int v0, e0, q0;

      vecs[0] = '{load: 13'd9,   p: 10,      byte_v: 8'hA5};
      vecs[1] = '{load: 13'd9,   p: 10,      byte_v: 8'h00};
      vecs[2] = '{load: 13'd1,   p: CLAMP_P, byte_v: 8'h6E};
      vecs[3] = '{load: 13'd0,   p: CLAMP_P, byte_v: 8'h96};
      vecs[4] = '{load: 13'd100, p: 101,     byte_v: 8'hC5};

      reset_n = 1'b0;
      rx      = 1'b1;
      set     = 1'b0;
      data    = '0;
      repeat (3) @(negedge clk);
      check("reset_rx_data",   {24'd0, rx_data}, 32'h00);
      check("reset_rx_valid",  {31'd0, rx_valid}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_busy",      {31'd0, busy}, 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("no_false_start", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         load_div(vecs[i].load);
         repeat (3) @(negedge clk);
         v0 = valid_cnt;
         e0 = err_cnt;
         drive_frame(vecs[i].byte_v, vecs[i].p, 1'b1, -1, 10 * vecs[i].p);
         wait_idle($sformatf("vec%0d_idle", i), 4 * vecs[i].p);
         check($sformatf("vec%0d_valid_cnt", i), valid_cnt - v0, 32'd1);
         check($sformatf("vec%0d_err_cnt", i), err_cnt - e0, 32'd0);
         check($sformatf("vec%0d_rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].byte_v});
         check($sformatf("vec%0d_busy_at_valid", i), {31'd0, busy_at_valid}, 32'd0);
      end

      // Back-to-back stream at P=10.
      load_div(13'd9);
      repeat (3) @(negedge clk);
      v0 = valid_cnt;
      q0 = rxq.size();
      drive_frame(8'h00, 10, 1'b1, -1, 100);
      drive_frame(8'hFF, 10, 1'b1, -1, 100);
      drive_frame(8'h3C, 10, 1'b1, -1, 100);
      wait_idle("b2b_idle", 40);
      check("b2b_valid_cnt", valid_cnt - v0, 32'd3);
      check("b2b_byte0", {24'd0, rxq[q0]},     32'h00);
      check("b2b_byte1", {24'd0, rxq[q0 + 1]}, 32'hFF);
      check("b2b_byte2", {24'd0, rxq[q0 + 2]}, 32'h3C);

      // Short low glitch: the start re-check at H=4 aborts.
      begin
         logic seen_busy;
         seen_busy = 1'b0;
         v0 = valid_cnt;
         e0 = err_cnt;
         @(negedge clk);
         rx = 1'b0;
         repeat (3) @(negedge clk);
         rx = 1'b1;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
         end
         check("glitch_busy_pulsed", {31'd0, seen_busy}, 32'd1);
         check("glitch_busy_low", {31'd0, busy}, 32'd0);
         check("glitch_no_valid", valid_cnt - v0, 32'd0);
         check("glitch_no_err", err_cnt - e0, 32'd0);
      end

      // Stop bit low followed by a 50-clock break.
      v0 = valid_cnt;
      e0 = err_cnt;
      drive_frame(8'h81, 10, 1'b0, -1, 100);
      repeat (50) @(negedge clk);
      check("break_err_cnt", err_cnt - e0, 32'd1);
      check("break_no_valid", valid_cnt - v0, 32'd0);
      check("break_rx_data", {24'd0, rx_data}, 32'h81);
      check("break_busy_held", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      wait_idle("break_release_idle", 10);
      repeat (40) @(negedge clk);
      check("break_no_retrigger_err", err_cnt - e0, 32'd1);
      check("break_no_retrigger_valid", valid_cnt - v0, 32'd0);

      // Divider load in the middle of a frame aborts it silently.
      v0 = valid_cnt;
      e0 = err_cnt;
      drive_frame(8'hA5, 10, 1'b1, -1, 35);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      check("set_busy_before", {31'd0, busy}, 32'd1);
      set  = 1'b1;
      data = 13'd19;
      @(negedge clk);
      set  = 1'b0;
      check("set_busy_dropped", {31'd0, busy}, 32'd0);
      repeat (40) @(negedge clk);
      check("set_no_valid", valid_cnt - v0, 32'd0);
      check("set_no_err", err_cnt - e0, 32'd0);
      drive_frame(8'h5A, 20, 1'b1, -1, 200);
      wait_idle("set_next_idle", 80);
      check("set_next_valid", valid_cnt - v0, 32'd1);
      check("set_next_data", {24'd0, rx_data}, 32'h5A);

      // Reset in the middle of DATA, then one frame at the default divider.
      drive_frame(8'hC3, 20, 1'b1, -1, 50);
      @(negedge clk);
      reset_n = 1'b0;
      rx      = 1'b1;
      #1;
      check("midreset_rx_data",   {24'd0, rx_data}, 32'h00);
      check("midreset_busy",      {31'd0, busy}, 32'd0);
      check("midreset_rx_valid",  {31'd0, rx_valid}, 32'd0);
      check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      v0 = valid_cnt;
      e0 = err_cnt;
      drive_frame(8'hC3, 6250, 1'b1, -1, 62500);
      wait_idle("default_div_idle", 12500);
      check("default_div_valid", valid_cnt - v0, 32'd1);
      check("default_div_err", err_cnt - e0, 32'd0);
      check("default_div_data", {24'd0, rx_data}, 32'hC3);

`ifdef UART_RX_MAJORITY_EN
      // Single-clock low glitch at the centre of bit 3 (clock H + 4*P = 44) is outvoted.
      load_div(13'd9);
      repeat (3) @(negedge clk);
      v0 = valid_cnt;
      drive_frame(8'hFF, 10, 1'b1, 44, 100);
      wait_idle("majority_idle", 40);
      check("majority_valid", valid_cnt - v0, 32'd1);
      check("majority_data", {24'd0, rx_data}, 32'hFF);
`endif

      check("valid_and_err_never_together", both_cnt, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
